// File: rtl/rr_mux_pkg.sv
// rr_mux shared package: clog2 helper and mode encodings.
// Imported by rr_mux_if, rr_mux_arb and rr_mux.
package rr_mux_pkg;

  localparam logic RR_MUX_MODE_RR    = 1'b0;
  localparam logic RR_MUX_MODE_FIXED = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_mux_if.sv
// rr_mux handshake bundle: N producer channels in, one registered beat out.
// slave = the mux side, master = producers/consumer side.
interface rr_mux_if
  import rr_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
);
  localparam int SW = (clog2(N) < 1) ? 1 : clog2(N);

  logic           flush;
  logic           mode;
  logic [SW-1:0]  fix_sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_chan;
  logic           out_ready;
  logic           sel_err;

  modport master (
    output flush, mode, fix_sel,
    output in_valid, in_data, in_last,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_last, out_chan,
    input  sel_err
  );

  modport slave (
    input  flush, mode, fix_sel,
    input  in_valid, in_data, in_last,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_last, out_chan,
    output sel_err
  );

endinterface

// File: rtl/rr_mux_arb.sv
// Combinational round-robin grant: first req at or after ptr, wrapping.
// Ports: req[N], ptr, lock_en, lock_chan in; one-hot grant[N] out.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          lock_en,
  input  logic [SW-1:0] lock_chan,
  output logic [N-1:0]  grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (lock_en) begin
      for (int i = 0; i < N; i++) begin
        if (int'(lock_chan) == i) grant[i] = req[i];
      end
    end else begin
      // Walk offsets from ptr; first hit wins.
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < N; i++) begin
          if (!found && req[i] &&
              ((int'(ptr) + k) % N == i)) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// rr_mux: N-channel W-bit registered selector, round-robin or fixed select.
// Ports: clk, reset (async, active-high), bus (rr_mux_if.slave).
// Optional burst lock when RR_MUX_LOCK_EN is defined.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic   clk,
  input  logic   reset,
  rr_mux_if.slave bus
);

  localparam int SW = (clog2(N) < 1) ? 1 : clog2(N);

  logic [SW-1:0] ptr;
  logic [SW-1:0] nxt_ptr;
  logic          load;
  logic          bad_sel;
  logic          xfer;
  logic          ptr_adv;
  logic [N-1:0]  rr_grant;
  logic [N-1:0]  fix_grant;
  logic [N-1:0]  grant;
  logic [W-1:0]  sel_data;
  logic          sel_last;
  logic [SW-1:0] sel_chan;
  logic          arb_lock;
  logic [SW-1:0] arb_chan;

  assign load = !bus.flush &&
                (!bus.out_valid || bus.out_ready);

  // fix_sel can exceed N-1 only when N is not a power of two.
  assign bad_sel = (bus.mode == RR_MUX_MODE_FIXED) &&
                   (int'(bus.fix_sel) >= N);

  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(bus.fix_sel) == i)
        fix_grant[i] = bus.in_valid[i];
    end
  end

  rr_mux_arb #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .lock_en   (arb_lock),
    .lock_chan (arb_chan),
    .grant     (rr_grant)
  );

  assign grant = (bus.mode == RR_MUX_MODE_FIXED) ?
                 fix_grant : rr_grant;

  assign bus.in_ready = load ? grant : '0;
  assign xfer = |bus.in_ready;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    sel_chan = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_data = bus.in_data[i*W +: W];
        sel_last = bus.in_last[i];
        sel_chan = SW'(i);
      end
    end
  end

  assign nxt_ptr = (int'(sel_chan) == N - 1) ?
                   '0 : sel_chan + SW'(1);

`ifdef RR_MUX_LOCK_EN
  logic          lock;
  logic [SW-1:0] lock_chan;

  assign arb_lock = lock &&
                    (bus.mode == RR_MUX_MODE_RR);
  assign arb_chan = lock_chan;
  // Pointer moves only once a burst completes.
  assign ptr_adv  = sel_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock      <= 1'b0;
      lock_chan <= '0;
    end else if (bus.flush ||
                 bus.mode == RR_MUX_MODE_FIXED) begin
      lock      <= 1'b0;
    end else if (xfer) begin
      lock      <= !sel_last;
      lock_chan <= sel_chan;
    end
  end
`else
  assign arb_lock = 1'b0;
  assign arb_chan = ptr;
  assign ptr_adv  = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer && ptr_adv &&
                 bus.mode == RR_MUX_MODE_RR) begin
      ptr <= nxt_ptr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_chan  <= '0;
      bus.sel_err   <= 1'b0;
    end else begin
      bus.sel_err <= bad_sel && !bus.flush;
      if (bus.flush) begin
        bus.out_valid <= 1'b0;
      end else if (xfer) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= sel_data;
        bus.out_last  <= sel_last;
        bus.out_chan  <= sel_chan;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: 4x32 round-robin instance and 3x8 fixed instance.
// Expected beats are queued at drive time and popped after the clock edge.
module tb_rr_mux;
  import rr_mux_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  chan;
    logic        last;
  } beat_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  beat_t q4[$];
  beat_t q3[$];

  rr_mux_if #(.N(4), .W(32)) b4 ();
  rr_mux_if #(.N(3), .W(8))  b3 ();

  rr_mux #(.N(4), .W(32)) u4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  rr_mux #(.N(3), .W(8)) u3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit big,
                      input logic [63:0] d,
                      input int c,
                      input logic l);
    beat_t e;
    e.data = d;
    e.chan = 4'(c);
    e.last = l;
    if (big) q4.push_back(e);
    else     q3.push_back(e);
  endtask

  task automatic pop(input bit big, input string tag);
    beat_t e;
    int    n;
    n = big ? q4.size() : q3.size();
    tests++;
    assert (n > 0) else begin
      fails++;
      $error("FAIL %s_sb observed=empty expected=beat", tag);
    end
    if (n > 0) begin
      e = big ? q4.pop_front() : q3.pop_front();
      if (big) begin
        chk({tag, "_v"}, 64'(b4.out_valid), 64'(1));
        chk({tag, "_d"}, 64'(b4.out_data), e.data);
        chk({tag, "_c"}, 64'(b4.out_chan), 64'(e.chan));
        chk({tag, "_l"}, 64'(b4.out_last), 64'(e.last));
      end else begin
        chk({tag, "_v"}, 64'(b3.out_valid), 64'(1));
        chk({tag, "_d"}, 64'(b3.out_data), e.data);
        chk({tag, "_c"}, 64'(b3.out_chan), 64'(e.chan));
        chk({tag, "_l"}, 64'(b3.out_last), 64'(e.last));
      end
    end
  endtask

  int ch0_cnt;
  int exp_seq[4];

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    b4.flush = 0; b4.mode = RR_MUX_MODE_RR; b4.fix_sel = '0;
    b4.in_valid = '0; b4.in_last = '1; b4.out_ready = 1'b1;
    b4.in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    b3.flush = 0; b3.mode = RR_MUX_MODE_RR; b3.fix_sel = '0;
    b3.in_valid = '0; b3.in_last = '1; b3.out_ready = 1'b1;
    b3.in_data = {8'h52, 8'h51, 8'h50};
    cyc();
    cyc();
    chk("rst_v4", 64'(b4.out_valid), 64'(0));
    chk("rst_d4", 64'(b4.out_data), 64'(0));
    chk("rst_c4", 64'(b4.out_chan), 64'(0));
    chk("rst_l4", 64'(b4.out_last), 64'(0));
    chk("rst_e3", 64'(b3.sel_err), 64'(0));
    chk("rst_v3", 64'(b3.out_valid), 64'(0));
    reset = 1'b0;

    // Round-robin over all four channels, wrapping to 0.
    b4.in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push(1, 64'(32'hA0 + (k % 4)), k % 4, 1'b1);
      cyc();
      pop(1, "rr_all");
    end

    // ptr=1: single ch1 beat moves ptr to 2.
    b4.in_valid = 4'b0010;
    push(1, 64'hA1, 1, 1'b1);
    cyc();
    pop(1, "ptr_set");
    // ch1 and ch3 valid with ptr=2: 3 then 1.
    b4.in_valid = 4'b1010;
    push(1, 64'hA3, 3, 1'b1);
    cyc();
    pop(1, "skip_a");
    push(1, 64'hA1, 1, 1'b1);
    cyc();
    pop(1, "skip_b");
    // ptr back at 2.
    b4.in_valid = 4'b1111;
    push(1, 64'hA2, 2, 1'b1);
    cyc();
    pop(1, "ptr_end");

    // Stall three cycles, then drain and load together.
    b4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_rdy", 64'(b4.in_ready), 64'(0));
      cyc();
      chk("stall_v", 64'(b4.out_valid), 64'(1));
      chk("stall_d", 64'(b4.out_data), 64'hA2);
    end
    b4.out_ready = 1'b1;
    #1;
    chk("drain_rdy", 64'(b4.in_ready), 64'b1000);
    push(1, 64'hA3, 3, 1'b1);
    cyc();
    pop(1, "drain");

    // Flush while stalled.
    b4.out_ready = 1'b0;
    b4.flush = 1'b1;
    #1;
    chk("flush_rdy", 64'(b4.in_ready), 64'(0));
    cyc();
    chk("flush_v", 64'(b4.out_valid), 64'(0));
    b4.flush = 1'b0;
    b4.out_ready = 1'b1;
    #1;
    chk("post_flush_rdy", 64'(b4.in_ready), 64'b0001);
    push(1, 64'hA0, 0, 1'b1);
    cyc();
    pop(1, "post_flush");

    // ptr=1: ch3 alone moves ptr to 0.
    b4.in_valid = 4'b1000;
    push(1, 64'hA3, 3, 1'b1);
    cyc();
    pop(1, "lock_prep");

    // ch0 three-beat burst with ch1 waiting.
`ifdef RR_MUX_LOCK_EN
    exp_seq = '{0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    ch0_cnt = 0;
    b4.in_valid = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      b4.in_last = {2'b11, 1'b1, ch0_cnt == 2};
      b4.in_data = {32'hA3, 32'hA2, 32'hC1,
                    32'hB0 + 32'(ch0_cnt)};
      if (exp_seq[k] == 0) begin
        push(1, 64'hB0 + 64'(ch0_cnt), 0, ch0_cnt == 2);
        ch0_cnt++;
      end else begin
        push(1, 64'hC1, 1, 1'b1);
      end
      cyc();
      pop(1, "burst");
    end

    // Reset mid-stream drops the held beat.
    reset = 1'b1;
    #1;
    chk("async_rst_v", 64'(b4.out_valid), 64'(0));
    chk("async_rst_d", 64'(b4.out_data), 64'(0));
    b4.in_valid = '0;
    cyc();
    reset = 1'b0;

    // N=3 fixed mode: out-of-range select.
    b3.mode = RR_MUX_MODE_FIXED;
    b3.fix_sel = 2'd3;
    b3.in_valid = 3'b111;
    b3.in_last = 3'b101;
    #1;
    chk("bad_rdy", 64'(b3.in_ready), 64'(0));
    cyc();
    chk("bad_err", 64'(b3.sel_err), 64'(1));
    chk("bad_v", 64'(b3.out_valid), 64'(0));
    b3.fix_sel = 2'd2;
    #1;
    chk("fix_rdy", 64'(b3.in_ready), 64'b100);
    push(0, 64'h52, 2, 1'b1);
    cyc();
    pop(0, "fix2");
    chk("err_pulse", 64'(b3.sel_err), 64'(0));
    // Selected channel not valid: no grant.
    b3.fix_sel = 2'd0;
    b3.in_valid = 3'b110;
    #1;
    chk("fix_inv_rdy", 64'(b3.in_ready), 64'(0));
    cyc();
    chk("fix_inv_v", 64'(b3.out_valid), 64'(0));

    // Back to round-robin: ptr untouched by fixed mode.
    b3.mode = RR_MUX_MODE_RR;
    b3.in_valid = 3'b111;
    b3.in_last = 3'b111;
    #1;
    chk("rr3_rdy", 64'(b3.in_ready), 64'b001);
    for (int k = 0; k < 4; k++) begin
      push(0, 64'h50 + 64'(k % 3), k % 3, 1'b1);
      cyc();
      pop(0, "rr3");
    end
    b3.in_valid = '0;
    cyc();
    chk("rr3_idle_v", 64'(b3.out_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-channel, W-bit registered selector with valid/ready handshakes; successor to the fixed 2/4-way datapath muxes. Selects one input channel per cycle either by round-robin arbitration or by an explicit select (fixed mode). The result is registered into a single output stage. Sits between multiple producers (e.g. writeback/forwarding sources, bus masters) and one consumer in the pipelined CPU datapath.

## Interface
- `N`, 4, number of input channels (2..16)
- `W`, 32, data width per channel (1..64)
- `SW`, derived `clog2(N)` with minimum 1, channel index width; not overridable
- `clk` input 1: rising-edge clock
- `reset` input 1: asynchronous, active-high reset
- `flush` input 1: synchronous clear of the output stage and the lock
- `mode` input 1: 0 = round-robin, 1 = fixed select
- `fix_sel` input SW: channel index used when `mode`=1
- `in_valid` input N: per-channel valid
- `in_data` input N*W: channel i occupies bits [i*W +: W]
- `in_last` input N: per-channel end-of-burst marker
- `in_ready` output N: per-channel accept; combinational
- `out_valid` output 1: output register holds a beat
- `out_data` output W: registered data
- `out_last` output 1: registered `in_last` of the accepted beat
- `out_chan` output SW: registered index of the source channel
- `out_ready` input 1: consumer accept
- `sel_err` output 1: registered one-cycle pulse

## Operation
- `load` = !flush && (!out_valid || out_ready). Beats accepted this cycle move into the output register at the next edge.
- Grant is one-hot and at most one channel:
  - Round-robin (`mode`=0): the first valid channel at or after `ptr`, wrapping N-1 -> 0.
  - Fixed (`mode`=1): channel `fix_sel` if `fix_sel` < N and `in_valid[fix_sel]`; otherwise no grant.
- `in_ready[i]` = `load` && `grant[i]`. Transfer on channel i = `in_valid[i]` && `in_ready[i]`.
- On transfer:
  - out_valid <= 1
  - out_data <= channel data
  - out_chan <= i
  - out_last <= `in_last[i]`
  - In round-robin mode, `ptr` <= (i+1) mod N. Fixed mode leaves `ptr` unchanged.
- On `out_ready` with no new transfer: out_valid <= 0. `out_data`, `out_chan` and `out_last` hold their last values.
- `sel_err` pulses high for one cycle after any cycle with `mode`=1 && `fix_sel` >= N && !flush. No transfer occurs in that cycle.
- `flush`: out_valid <= 0 and the lock is cleared. `ptr` is kept. All `in_ready` are 0 in that cycle. `flush` wins over every other event.
- `mode` may change on any cycle. The beat already in the output register is unaffected.

## Timing
- Input to output latency: 1 cycle. Sustained throughput is 1 beat/cycle while `out_ready`=1.
- Output stalls (`out_valid` && !`out_ready`): all `in_ready` = 0, and the output register holds stable.
- A beat in the output register can be consumed and a new beat accepted in the same cycle.
- Reset values:
  - out_valid 0, out_data 0, out_last 0, out_chan 0, sel_err 0
  - ptr 0, lock inactive
- Reset asserted mid-transfer drops the in-flight beat. Nothing is replayed.
- If no channel is valid, `ptr` does not move.

## Configuration
- `RR_MUX_LOCK_EN` defined:
  - In round-robin mode, after a transfer from channel k with `in_last[k]`=0, the grant locks to k.
  - While locked, only k may be granted, even if other channels are valid.
  - The lock releases on a transfer with `in_last`=1, on `flush`, on reset, or on any cycle with `mode`=1.
  - `ptr` advances only when the lock releases on a last beat.
- `RR_MUX_LOCK_EN` undefined:
  - No lock state. Every beat arbitrates independently.
  - `in_last` is only passed through to `out_last`.
- Ports are identical in both builds.

## Structure
- Package `rr_mux_pkg` holds:
  - `clog2` function
  - Mode constants `RR_MUX_MODE_RR`=1'b0 and `RR_MUX_MODE_FIXED`=1'b1
- Sub-module `rr_mux_arb`: purely combinational round-robin grant.
  - Inputs: `req` [N], `ptr` [SW], `lock_en`, `lock_chan`.
  - Output: one-hot `grant` [N].
- The top level holds the output register, `ptr`, the lock, fixed-mode decode and `sel_err`.

## Test plan
- N=4, W=32, `mode`=0, all channels valid with data 0xA0+i, `out_ready`=1 -> `out_chan` sequence 0,1,2,3,0 on consecutive cycles; `out_data` 0xA0..0xA3.
- Only channels 1 and 3 valid, `ptr`=2 -> channel 3 is granted first, then 1; `ptr` ends at 2.
- `out_ready`=0 for 3 cycles with a beat held -> `out_data` stable, `in_ready`=0000; `out_ready`=1 -> the held beat drains and the next beat loads in the same cycle.
- N=3, `mode`=1, `fix_sel`=3 with all channels valid -> no transfer, `sel_err`=1 for exactly one cycle; `fix_sel`=2 -> channel 2 data appears after 1 cycle.
- `flush` asserted with `out_valid`=1 and `out_ready`=0 -> `out_valid`=0 the next cycle, `in_ready` all 0 during `flush`, `ptr` unchanged.
- With `RR_MUX_LOCK_EN`: channel 0 sends 3 beats (last on the 3rd) while channel 1 is valid -> `out_chan` = 0,0,0,1. Without the macro -> `out_chan` = 0,1,0,1.
